// File: rtl/alu_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_buffer
//  Description : First-word-fall-through circular FIFO that queues ALU
//                results ({cf, zero, result}) for a downstream consumer.
//                The producer never stalls, so a push into a full buffer
//                without a same-cycle pop drops the result and sets a
//                sticky overflow flag.
//                Optional macro RESULT_BUF_STATS_EN builds saturating
//                8-bit counters of accepted results with zero / carry set;
//                without it the counter outputs are tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_result_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4    // power of two, at least 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [WIDTH-1:0]         i_result,
    input  logic                     i_zero,
    input  logic                     i_cf,
    input  logic                     i_ready,
    input  logic                     i_clr,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_result,
    output logic                     o_zero,
    output logic                     o_cf,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_overflow,
    output logic [7:0]               o_zero_cnt,
    output logic [7:0]               o_cf_cnt
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_ENTRY_W = WIDTH + 2;

    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_overflow;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_CNT);

    // A pop frees a slot in the same cycle, so a full buffer can still accept
    assign w_pop  = !w_empty && i_ready;
    assign w_push = i_valid && (!w_full || w_pop);
    assign w_drop = i_valid && !w_push;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; only the pointers define which entries are live
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {i_cf, i_zero, i_result};
    end

    // Sticky overflow; a new drop takes priority over a same-cycle clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_overflow <= 1'b0;
        else if (w_drop)
            r_overflow <= 1'b1;
        else if (i_clr)
            r_overflow <= 1'b0;
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign o_result   = w_head[WIDTH-1:0];
    assign o_zero     = w_head[WIDTH];
    assign o_cf       = w_head[WIDTH+1];
    assign o_valid    = !w_empty;
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;

`ifdef RESULT_BUF_STATS_EN
    logic [7:0] r_zero_cnt;
    logic [7:0] r_cf_cnt;

    // Saturating flag statistics over accepted results; clear beats increment
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_zero_cnt <= 8'd0;
            r_cf_cnt   <= 8'd0;
        end else if (i_clr) begin
            r_zero_cnt <= 8'd0;
            r_cf_cnt   <= 8'd0;
        end else begin
            if (w_push && i_zero && (r_zero_cnt != 8'hFF))
                r_zero_cnt <= r_zero_cnt + 8'd1;
            if (w_push && i_cf && (r_cf_cnt != 8'hFF))
                r_cf_cnt <= r_cf_cnt + 8'd1;
        end
    end

    assign o_zero_cnt = r_zero_cnt;
    assign o_cf_cnt   = r_cf_cnt;
`else
    assign o_zero_cnt = 8'd0;
    assign o_cf_cnt   = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_result_buffer
//  Description : Self-checking bench for alu_result_buffer. A queue-based
//                reference model tracks buffer contents, the sticky overflow
//                flag and the flag statistics; directed scenarios are followed
//                by a randomized run compared against the model every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_result_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic                   i_clk;
    logic                   i_rst;
    logic                   i_valid;
    logic [WIDTH-1:0]       i_result;
    logic                   i_zero;
    logic                   i_cf;
    logic                   i_ready;
    logic                   i_clr;
    logic                   o_valid;
    logic [WIDTH-1:0]       o_result;
    logic                   o_zero;
    logic                   o_cf;
    logic [$clog2(DEPTH):0] o_count;
    logic                   o_full;
    logic                   o_empty;
    logic                   o_overflow;
    logic [7:0]             o_zero_cnt;
    logic [7:0]             o_cf_cnt;

    alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_result   (i_result),
        .i_zero     (i_zero),
        .i_cf       (i_cf),
        .i_ready    (i_ready),
        .i_clr      (i_clr),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .o_zero     (o_zero),
        .o_cf       (o_cf),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_overflow (o_overflow),
        .o_zero_cnt (o_zero_cnt),
        .o_cf_cnt   (o_cf_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of {cf, zero, result}
    logic [WIDTH+1:0] m_q[$];
    logic             m_ovf;
    int               m_zcnt;
    int               m_ccnt;

    function automatic int exp_zcnt();
`ifdef RESULT_BUF_STATS_EN
        return m_zcnt;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_ccnt();
`ifdef RESULT_BUF_STATS_EN
        return m_ccnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_ovf  = 1'b0;
        m_zcnt = 0;
        m_ccnt = 0;
    endtask

    // Drive one cycle of inputs, clock it, update the model, settle past the edge
    task automatic apply(input logic v, input logic [WIDTH-1:0] d, input logic z,
                         input logic c, input logic rdy, input logic clr);
        bit pop, push;
        i_valid  = v;
        i_result = d;
        i_zero   = z;
        i_cf     = c;
        i_ready  = rdy;
        i_clr    = clr;
        pop  = (m_q.size() > 0) && rdy;
        push = v && ((m_q.size() < DEPTH) || pop);
        @(posedge i_clk);
        #1;
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back({c, z, d});
        if (v && !push) m_ovf = 1'b1;
        else if (clr)   m_ovf = 1'b0;
        if (clr) begin
            m_zcnt = 0;
            m_ccnt = 0;
        end else if (push) begin
            if (z && m_zcnt < 255) m_zcnt++;
            if (c && m_ccnt < 255) m_ccnt++;
        end
        i_valid = 1'b0;
        i_clr   = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_valid = 1'b0; i_result = '0; i_zero = 1'b0; i_cf = 1'b0;
        i_ready = 1'b0; i_clr = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        model_clear();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) apply(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (o_valid !== 1'b0 || o_count !== 0 || o_empty !== 1'b1 || o_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_occupancy: got valid=%b count=%0d empty=%b full=%b, want 0/0/1/0",
                     o_valid, o_count, o_empty, o_full);
        end
        n_checks++;
        if (o_overflow !== 1'b0 || o_zero_cnt !== 8'd0 || o_cf_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got ovf=%b zcnt=%0d ccnt=%0d, want 0/0/0",
                     o_overflow, o_zero_cnt, o_cf_cnt);
        end
    endtask

    task automatic test_first_push();
        apply(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (o_valid !== 1'b1 || o_result !== 8'h12 || o_count !== 1 || o_zero !== 1'b0 || o_cf !== 1'b0) begin
            n_fail++;
            $display("FAIL first_push: got valid=%b result=%h count=%0d z=%b c=%b, want 1/12/1/0/0",
                     o_valid, o_result, o_count, o_zero, o_cf);
        end
        drain();
    endtask

    task automatic test_no_bypass();
        apply(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (o_count !== 1 || o_valid !== 1'b1 || o_result !== 8'h5A || o_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL no_bypass: got count=%0d valid=%b result=%h z=%b, want 1/1/5a/1",
                     o_count, o_valid, o_result, o_zero);
        end
        drain();
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) apply(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (o_full !== 1'b1 || o_count !== 4) begin
            n_fail++;
            $display("FAIL fill_full: got full=%b count=%0d, want 1/4", o_full, o_count);
        end
        for (int i = 0; i < 4; i++) begin
            exp = 8'hA1 + 8'(i);
            n_checks++;
            if (o_valid !== 1'b1 || o_result !== exp) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: got valid=%b result=%h, want 1/%h", i, o_valid, o_result, exp);
            end
            apply(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        n_checks++;
        if (o_empty !== 1'b1 || o_valid !== 1'b0 || o_count !== 0) begin
            n_fail++;
            $display("FAIL drain_empty: got empty=%b valid=%b count=%0d, want 1/0/0", o_empty, o_valid, o_count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) apply(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (o_overflow !== 1'b1 || o_count !== 4 || o_result !== 8'hB0) begin
            n_fail++;
            $display("FAIL overflow_drop: got ovf=%b count=%0d head=%h, want 1/4/b0", o_overflow, o_count, o_result);
        end
        apply(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (o_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: got %b, want 1", o_overflow);
        end
        apply(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clr: got %b, want 0", o_overflow);
        end
        // Drop and clear in the same cycle: drop wins
        apply(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_drop_vs_clr: got %b, want 1", o_overflow);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (o_result !== 8'hB0 + 8'(i)) begin
                n_fail++;
                $display("FAIL overflow_contents[%0d]: got %h, want %h", i, o_result, 8'hB0 + 8'(i));
            end
            apply(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        apply(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) apply(1'b1, 8'hC1 + 8'(i), 1'b1, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (o_count !== 4 || o_overflow !== 1'b0 || o_result !== 8'hC2) begin
            n_fail++;
            $display("FAIL full_push_pop: got count=%0d ovf=%b head=%h, want 4/0/c2", o_count, o_overflow, o_result);
        end
        for (int i = 0; i < 4; i++) begin
            exp = (i == 3) ? 8'h77 : 8'hC2 + 8'(i);
            n_checks++;
            if (o_result !== exp) begin
                n_fail++;
                $display("FAIL full_push_pop_order[%0d]: got %h, want %h", i, o_result, exp);
            end
            apply(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_stats();
        apply(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) apply(1'b1, 8'(i), 1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (o_zero_cnt !== 8'(exp_zcnt()) || o_cf_cnt !== 8'(exp_ccnt())) begin
            n_fail++;
            $display("FAIL stats_saturate: got zcnt=%0d ccnt=%0d, want %0d/%0d",
                     o_zero_cnt, o_cf_cnt, exp_zcnt(), exp_ccnt());
        end
        // Clear coinciding with an accepted flagged push: clear wins
        drain();
        apply(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (o_zero_cnt !== 8'd0 || o_cf_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL stats_clr: got zcnt=%0d ccnt=%0d, want 0/0", o_zero_cnt, o_cf_cnt);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) apply(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 8'hE3, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 8'hE4, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 i_rst = 1'b1;
        #1;
        n_checks++;
        if (o_count !== 0 || o_valid !== 1'b0 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got count=%0d valid=%b ovf=%b, want 0/0/0", o_count, o_valid, o_overflow);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        model_clear();
        apply(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (o_count !== 1 || o_result !== 8'h3C || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got count=%0d head=%h ovf=%b, want 1/3c/0", o_count, o_result, o_overflow);
        end
        drain();
    endtask

    task automatic test_random();
        logic [WIDTH+1:0] h;
        int bad = 0;
        for (int n = 0; n < 600; n++) begin
            apply($urandom_range(0, 9) < 6, WIDTH'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
            n_checks++;
            if (o_count !== ($clog2(DEPTH)+1)'(m_q.size()) || o_valid !== (m_q.size() > 0) ||
                o_empty !== (m_q.size() == 0) || o_full !== (m_q.size() == DEPTH) ||
                o_overflow !== m_ovf || o_zero_cnt !== 8'(exp_zcnt()) || o_cf_cnt !== 8'(exp_ccnt())) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_state[%0d]: got count=%0d ovf=%b zc=%0d cc=%0d, want %0d/%b/%0d/%0d",
                             n, o_count, o_overflow, o_zero_cnt, o_cf_cnt, m_q.size(), m_ovf, exp_zcnt(), exp_ccnt());
            end
            if (m_q.size() > 0) begin
                h = m_q[0];
                n_checks++;
                if ({o_cf, o_zero, o_result} !== h) begin
                    n_fail++;
                    bad++;
                    if (bad < 10)
                        $display("FAIL random_head[%0d]: got %h, want %h", n, {o_cf, o_zero, o_result}, h);
                end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_first_push();
        test_no_bypass();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_stats();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter WIDTH, default 8, result data width; SHALL match the upstream ALU stage width.
REQ-002 Parameter DEPTH, default 4, number of entries; SHALL be a power of two and at least 2.
REQ-003 i_clk  input  1  clock; all state changes on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_valid  input  1  upstream result valid; there is no upstream ready, so the producer never stalls.
REQ-006 i_result  input  WIDTH  upstream result.
REQ-007 i_zero  input  1  upstream zero flag.
REQ-008 i_cf  input  1  upstream carry flag.
REQ-009 i_ready  input  1  downstream consumer ready.
REQ-010 i_clr  input  1  synchronous clear of the sticky overflow flag and the statistics counters.
REQ-011 o_valid  output  1  head entry valid.
REQ-012 o_result  output  WIDTH  head result.
REQ-013 o_zero  output  1  head zero flag.
REQ-014 o_cf  output  1  head carry flag.
REQ-015 o_count  output  clog2(DEPTH)+1  current occupancy.
REQ-016 o_full  output  1  occupancy equals DEPTH.
REQ-017 o_empty  output  1  occupancy equals 0.
REQ-018 o_overflow  output  1  sticky: at least one result was dropped.
REQ-019 o_zero_cnt  output  8  count of accepted results with zero flag set.
REQ-020 o_cf_cnt  output  8  count of accepted results with carry flag set.

Function
REQ-021 Entry format SHALL be {cf, zero, result}; the block SHALL be a circular FIFO with read pointer, write pointer and occupancy counter.
REQ-022 Push SHALL occur when i_valid=1 and either (occupancy < DEPTH) or a pop occurs in the same cycle.
REQ-023 Pop SHALL occur when o_valid=1 and i_ready=1.
REQ-024 Output SHALL be first-word fall-through: o_valid=!o_empty, with head fields driven from storage at the read pointer without extra delay.
REQ-025 Latency: a result pushed on edge N into an empty buffer SHALL appear on o_valid/o_result/o_zero/o_cf after edge N.
REQ-026 Push and pop in the same cycle SHALL leave occupancy unchanged, and both pointers SHALL advance.
REQ-027 Push when empty with i_ready=1 SHALL NOT pop in that cycle; there is no bypass.
REQ-028 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-029 When i_valid=1, the buffer is full and no pop occurs:
  - the result SHALL be dropped;
  - contents SHALL be unchanged;
  - o_overflow SHALL be set on that edge.
REQ-030 o_overflow SHALL remain 1 until i_clr=1 or reset; if i_clr and a new drop coincide, the drop SHALL win (o_overflow=1).
REQ-031 Output fields SHALL hold stable while o_valid=1 and i_ready=0.
REQ-032 o_count, o_full and o_empty SHALL be registered-state derived and consistent in every cycle.

Reset
REQ-033 On i_rst=1, the following SHALL reset asynchronously:
  - pointers to 0;
  - occupancy to 0 (o_empty=1, o_full=0, o_valid=0);
  - o_overflow to 0;
  - o_zero_cnt and o_cf_cnt to 0.
REQ-034 Storage contents SHALL NOT be reset; o_result/o_zero/o_cf are don't-care while o_valid=0.
REQ-035 Reset asserted mid-operation SHALL discard all entries; the first push after release SHALL be the first popped.

Configuration
REQ-036 Macro RESULT_BUF_STATS_EN defined:
  - o_zero_cnt SHALL increment by 1 on each push with zero flag set;
  - o_cf_cnt SHALL increment by 1 on each push with carry flag set;
  - both counters SHALL saturate at 255;
  - i_clr SHALL zero them, with i_clr winning over a same-cycle increment.
REQ-037 Macro RESULT_BUF_STATS_EN undefined: no counter logic SHALL be built; o_zero_cnt and o_cf_cnt SHALL be tied to 0, and ports SHALL be unchanged.

Verification
REQ-038 Reset, push 0x12/z0/c0 with i_ready=0 -> next cycle o_valid=1, o_result=0x12, o_count=1.
REQ-039 Push 0xA1,0xA2,0xA3,0xA4 (DEPTH=4), i_ready=0 -> o_full=1; then i_ready=1 for 4 cycles -> pops in order 0xA1..0xA4, o_empty=1.
REQ-040 Full buffer, i_valid=1 with 0x55, i_ready=0 -> 0x55 dropped, o_overflow=1, o_count=4; pulse i_clr -> o_overflow=0.
REQ-041 Full buffer, i_valid=1 with 0x77 and i_ready=1 -> head popped, 0x77 accepted, o_count stays 4, 0x77 popped last.
REQ-042 STATS_EN defined: 300 pushes with zero=1, cf=1 -> o_zero_cnt=255, o_cf_cnt=255; undefined -> both 0.
REQ-043 Push 3 entries, assert i_rst mid-stream, release, push 0x3C -> o_count=1, head 0x3C, o_overflow=0.
